axi_err_responder: RTL and testbench

- AXI4 subordinate endpoint that terminates every transaction it receives with a fixed error response.
- Placed at the far end of an AXI link, e.g. behind a crossbar default port or an unmapped address window, so any initiator access completes protocol-correctly instead of hanging.
- Write and read paths are independent FSMs. Each path handles one outstanding transaction; full bursts are honoured.

---
 rtl/axi_err_responder.sv | 179 +++++++++++++++++
 tb/tb_axi_err_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_err_responder.sv
// AXI4 subordinate that terminates every write and read with a fixed error response.
// Write and read paths are independent FSMs, each holding one outstanding transaction.
module axi_err_responder #(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned DataWidth = 64,
  parameter logic [1:0]  RespCode  = 2'b11,
  parameter logic [63:0] RespData  = 64'hCA11_AB1E_BADC_AB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // write address
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [7:0]           aw_len_i,
  // write data
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  // write response
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  // read address
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,
  // read data
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o
);

  // Zero-extends or truncates the 64-bit pattern to the bus width.
  localparam logic [DataWidth-1:0] RDataW = DataWidth'(RespData);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  w_state_e           w_state_q, w_state_d;
  logic [IdWidth-1:0] w_id_q, w_id_d;

  r_state_e           r_state_q, r_state_d;
  logic [IdWidth-1:0] r_id_q, r_id_d;
  logic [7:0]         cnt_q, cnt_d;

  // The burst is terminated by w_last alone, so the write length is not needed.
  logic unused_aw_len;
  assign unused_aw_len = ^aw_len_i;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_valid_i) begin
          w_id_d    = aw_id_i;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_valid_i && w_last_i) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_ready_i) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    case (w_state_q)
      W_IDLE:  aw_ready_o = 1'b1;
      W_DATA:  w_ready_o  = 1'b1;
      W_RESP:  b_valid_o  = 1'b1;
      default: aw_ready_o = 1'b0;
    endcase
  end

  assign b_id_o   = w_id_q;
  assign b_resp_o = RespCode;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      cnt_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      cnt_q     <= cnt_d;
    end
  end

  // cnt holds the number of beats still to send after the current one.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    cnt_d     = cnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_valid_i) begin
          r_id_d    = ar_id_i;
          cnt_d     = ar_len_i;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_ready_i) begin
          if (cnt_q == 8'd0) begin
            r_state_d = R_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_last_o   = 1'b0;
    case (r_state_q)
      R_IDLE: ar_ready_o = 1'b1;
      R_DATA: begin
        r_valid_o = 1'b1;
        r_last_o  = (cnt_q == 8'd0);
      end
      default: ar_ready_o = 1'b0;
    endcase
  end

  assign r_id_o   = r_id_q;
  assign r_data_o = RDataW;
  assign r_resp_o = RespCode;

endmodule

// File: tb/tb_axi_err_responder.sv
// Randomized self-checking bench for axi_err_responder: a transaction-level
// model tracks open writes/reads and predicts every ready/valid/id each cycle.
module tb_axi_err_responder;

  localparam int          IdW   = 4;
  localparam int          DW    = 64;
  localparam logic [63:0] RDATA = 64'hCA11_AB1E_BADC_AB1E;
  localparam logic [1:0]  RESP  = 2'b11;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           aw_valid_i, aw_ready_o;
  logic [IdW-1:0] aw_id_i;
  logic [7:0]     aw_len_i;
  logic           w_valid_i, w_ready_o, w_last_i;
  logic           b_valid_o, b_ready_i;
  logic [IdW-1:0] b_id_o;
  logic [1:0]     b_resp_o;
  logic           ar_valid_i, ar_ready_o;
  logic [IdW-1:0] ar_id_i;
  logic [7:0]     ar_len_i;
  logic           r_valid_o, r_ready_i;
  logic [IdW-1:0] r_id_o;
  logic [DW-1:0]  r_data_o;
  logic [1:0]     r_resp_o;
  logic           r_last_o;

  axi_err_responder #(
    .IdWidth(IdW), .DataWidth(DW), .RespCode(RESP), .RespData(RDATA)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_len_i(aw_len_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_len_i(ar_len_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Initiator-side stimulus queues.
  typedef struct { logic [IdW-1:0] id; int beats; } txn_t;
  txn_t aw_q[$];
  txn_t ar_q[$];
  bit   w_q[$];
  int   p_aw = 100, p_w = 100, p_b = 100, p_ar = 100, p_r = 100;
  bit   w_early = 0;

  // Transaction-level reference model.
  bit             m_aw_done, m_last_done;
  logic [IdW-1:0] m_wid;
  int             m_rleft;
  logic [IdW-1:0] m_rid;

  // Handshakes observed on the DUT pins.
  int cyc = 0;
  int obs_w_hs = 0, obs_b_hs = 0, obs_r_hs = 0, obs_r_last = 0;
  int aw_hs_cyc = -1, ar_hs_cyc = -2;
  logic [IdW-1:0] last_b_id = '0;

  bit aw_fire, w_fire, ar_fire;

  function automatic bit pct(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  function automatic bit busy();
    return (aw_q.size() != 0) || (w_q.size() != 0) || (ar_q.size() != 0) ||
           m_aw_done || (m_rleft != 0);
  endfunction

  task automatic cycle();
    bit b_fire, r_fire;
    @(negedge clk_i);
    cyc++;
    if (aw_fire) aw_valid_i = 1'b0;
    if (w_fire)  w_valid_i  = 1'b0;
    if (ar_fire) ar_valid_i = 1'b0;

    if (!aw_valid_i && aw_q.size() != 0 && pct(p_aw)) begin
      aw_valid_i = 1'b1;
      aw_id_i    = aw_q[0].id;
      aw_len_i   = 8'(aw_q[0].beats - 1);
    end
    if (!w_valid_i && w_q.size() != 0 && (w_early || (m_aw_done && !m_last_done)) && pct(p_w)) begin
      w_valid_i = 1'b1;
      w_last_i  = w_q[0];
    end
    b_ready_i = pct(p_b);
    if (!ar_valid_i && ar_q.size() != 0 && pct(p_ar)) begin
      ar_valid_i = 1'b1;
      ar_id_i    = ar_q[0].id;
      ar_len_i   = 8'(ar_q[0].beats - 1);
    end
    r_ready_i = pct(p_r);

    check("aw_ready", 64'(aw_ready_o), 64'(!m_aw_done));
    check("w_ready",  64'(w_ready_o),  64'(m_aw_done && !m_last_done));
    check("b_valid",  64'(b_valid_o),  64'(m_last_done));
    if (m_last_done) begin
      check("b_id",   64'(b_id_o),   64'(m_wid));
      check("b_resp", 64'(b_resp_o), 64'(RESP));
    end
    check("ar_ready", 64'(ar_ready_o), 64'(m_rleft == 0));
    check("r_valid",  64'(r_valid_o),  64'(m_rleft != 0));
    check("r_last",   64'(r_last_o),   64'(m_rleft == 1));
    if (m_rleft != 0) begin
      check("r_id",   64'(r_id_o),   64'(m_rid));
      check("r_data", 64'(r_data_o), RDATA);
      check("r_resp", 64'(r_resp_o), 64'(RESP));
    end

    if (w_valid_i && w_ready_o) obs_w_hs++;
    if (b_valid_o && b_ready_i) begin obs_b_hs++; last_b_id = b_id_o; end
    if (r_valid_o && r_ready_i) begin obs_r_hs++; if (r_last_o) obs_r_last++; end
    if (aw_valid_i && aw_ready_o) aw_hs_cyc = cyc;
    if (ar_valid_i && ar_ready_o) ar_hs_cyc = cyc;

    aw_fire = aw_valid_i && !m_aw_done;
    w_fire  = w_valid_i && m_aw_done && !m_last_done;
    b_fire  = b_ready_i && m_last_done;
    ar_fire = ar_valid_i && (m_rleft == 0);
    r_fire  = r_ready_i && (m_rleft != 0);

    if (b_fire) begin m_aw_done = 0; m_last_done = 0; end
    if (w_fire) begin
      if (w_last_i) m_last_done = 1;
      void'(w_q.pop_front());
    end
    if (aw_fire) begin m_aw_done = 1; m_wid = aw_id_i; void'(aw_q.pop_front()); end
    if (r_fire) m_rleft--;
    if (ar_fire) begin m_rleft = ar_q[0].beats; m_rid = ar_id_i; void'(ar_q.pop_front()); end
  endtask

  task automatic run_until_done(input int limit);
    int n = 0;
    while (busy() && n < limit) begin
      cycle();
      n++;
    end
    check("drain_timeout", 64'(busy()), 64'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push_write(input logic [IdW-1:0] id, input int beats);
    txn_t t;
    t.id = id; t.beats = beats;
    aw_q.push_back(t);
    for (int i = 0; i < beats; i++) w_q.push_back(i == beats - 1);
  endtask

  task automatic push_read(input logic [IdW-1:0] id, input int beats);
    txn_t t;
    t.id = id; t.beats = beats;
    ar_q.push_back(t);
  endtask

  // Reset may be applied at any point; everything in flight is discarded.
  task automatic do_reset();
    rst_ni     = 1'b0;
    aw_valid_i = 0; aw_id_i = '0; aw_len_i = '0;
    w_valid_i  = 0; w_last_i = 0; b_ready_i = 0;
    ar_valid_i = 0; ar_id_i = '0; ar_len_i = '0; r_ready_i = 0;
    aw_q.delete(); ar_q.delete(); w_q.delete();
    m_aw_done = 0; m_last_done = 0; m_rleft = 0;
    aw_fire = 0; w_fire = 0; ar_fire = 0;
    #1;
    check("rst_aw_ready", 64'(aw_ready_o), 64'd1);
    check("rst_ar_ready", 64'(ar_ready_o), 64'd1);
    check("rst_w_ready",  64'(w_ready_o),  64'd0);
    check("rst_b_valid",  64'(b_valid_o),  64'd0);
    check("rst_r_valid",  64'(r_valid_o),  64'd0);
    check("rst_r_last",   64'(r_last_o),   64'd0);
    check("rst_b_id",     64'(b_id_o),     64'd0);
    check("rst_r_id",     64'(r_id_o),     64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  int w0, b0, r0, rl0;

  initial begin
    do_reset();
    run(3);

    // Single-beat write, id 3, B accepted immediately.
    b0 = obs_b_hs;
    push_write(4'h3, 1);
    run_until_done(50);
    run(2);
    check("wr1_b_count", 64'(obs_b_hs - b0), 64'd1);
    check("wr1_b_id",    64'(last_b_id),     64'h3);

    // Four-beat read at full throughput.
    r0 = obs_r_hs; rl0 = obs_r_last;
    push_read(4'hA, 4);
    run_until_done(50);
    check("rd4_beats", 64'(obs_r_hs - r0),    64'd4);
    check("rd4_lasts", 64'(obs_r_last - rl0), 64'd1);

    // 256-beat read with a randomly stalling r_ready.
    p_r = 50;
    r0 = obs_r_hs; rl0 = obs_r_last;
    push_read(4'h5, 256);
    run_until_done(3000);
    check("rd256_beats", 64'(obs_r_hs - r0),    64'd256);
    check("rd256_lasts", 64'(obs_r_last - rl0), 64'd1);
    p_r = 100;

    // Three W beats offered two cycles before their AW.
    w_early = 1;
    w0 = obs_w_hs; b0 = obs_b_hs;
    for (int i = 0; i < 3; i++) w_q.push_back(i == 2);
    run(2);
    check("early_w_blocked", 64'(obs_w_hs - w0), 64'd0);
    begin
      txn_t t;
      t.id = 4'h7; t.beats = 3;
      aw_q.push_back(t);
    end
    run_until_done(50);
    check("early_w_beats", 64'(obs_w_hs - w0), 64'd3);
    check("early_b_count", 64'(obs_b_hs - b0), 64'd1);
    w_early = 0;

    // Concurrent AW and AR; B held off while the read completes.
    p_b = 0;
    b0 = obs_b_hs; r0 = obs_r_hs;
    push_write(4'h1, 1);
    push_read(4'h2, 2);
    run(5);
    check("conc_same_cycle", 64'(aw_hs_cyc), 64'(ar_hs_cyc));
    check("conc_r_beats",    64'(obs_r_hs - r0), 64'd2);
    check("conc_b_waiting",  64'(obs_b_hs - b0), 64'd0);
    p_b = 100;
    run_until_done(20);
    check("conc_b_count", 64'(obs_b_hs - b0), 64'd1);
    check("conc_b_id",    64'(last_b_id),     64'h1);

    // Reset mid-read with six beats still outstanding.
    r0 = obs_r_hs;
    push_read(4'hC, 8);
    while (m_rleft != 6 && cyc < 100000) cycle();
    @(posedge clk_i);
    #3;
    do_reset();
    run(4);
    check("rst_mid_read_beats", 64'(obs_r_hs - r0), 64'd2);

    // Random mixed traffic.
    w_early = 1;
    p_aw = 60; p_w = 70; p_b = 60; p_ar = 60; p_r = 65;
    b0 = obs_b_hs; rl0 = obs_r_last;
    for (int i = 0; i < 150; i++) begin
      push_write(IdW'($urandom), $urandom_range(4, 1));
      push_read(IdW'($urandom), $urandom_range(16, 1));
    end
    run_until_done(20000);
    check("rand_writes", 64'(obs_b_hs - b0),    64'd150);
    check("rand_reads",  64'(obs_r_last - rl0), 64'd150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
